// File: rtl/selevy_ctrl_pkg.sv
// Shared constants for the selevy multicycle controller: state codes, opcodes,
// PC/writeback select codes and small opcode-classification helpers.
package selevy_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_REL  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  // SYSTEM is handled separately by the decoder, so it is not listed here.
  function automatic logic opc_known(input logic [6:0] opc);
    logic known;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: known = 1'b1;
      default:                               known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic logic opc_uses_imm(input logic [6:0] opc);
    logic imm;
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JALR: imm = 1'b1;
      default:                                                      imm = 1'b0;
    endcase
    return imm;
  endfunction

  function automatic logic [1:0] wb_sel_for(input logic [6:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_LOAD:           sel = WB_SEL_MEM;
      OPC_JAL, OPC_JALR:  sel = WB_SEL_LINK;
      default:            sel = WB_SEL_ALU;
    endcase
    return sel;
  endfunction

  function automatic logic [1:0] pc_sel_for(input logic [6:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_JAL:  sel = PC_SEL_REL;
      OPC_JALR: sel = PC_SEL_JALR;
      default:  sel = PC_SEL_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/selevy_ctrl_if.sv
// Control/datapath handshake bundle between the selevy controller (master)
// and the ROM, data memory, regfile and PC datapath (slave).
interface selevy_ctrl_if;
  logic       imem_req;
  logic       imem_ack;
  logic       ir_we;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       alu_src_imm;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       rf_we;
  logic [1:0] wb_sel;

  modport master (
    output imem_req, ir_we, alu_src_imm, dmem_req, dmem_we,
           pc_we, pc_sel, rf_we, wb_sel,
    input  imem_ack, opcode, branch_taken, dmem_ack
  );

  modport slave (
    input  imem_req, ir_we, alu_src_imm, dmem_req, dmem_we,
           pc_we, pc_sel, rf_we, wb_sel,
    output imem_ack, opcode, branch_taken, dmem_ack
  );
endinterface

// File: rtl/selevy_ctrl_timeout.sv
// Request/ack watchdog shared by instruction fetch and data-memory access;
// expire flags the cycle in which the wait reaches LIMIT-1 with no ack.
module selevy_ctrl_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack,
  input  logic clr,
  output logic expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 2);

  logic [CW-1:0] cnt_r;

  // An ack in the expiry cycle suppresses the trap.
  assign expire = req & ~ack & (cnt_r == LAST);

  // Wait-cycle counter; any state change, ack or idle cycle restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr || !req || ack) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/selevy_ctrl.sv
// Multicycle control sequencer for the selevy core: steps each instruction
// through fetch/decode/execute/memory/writeback and drives datapath strobes.
module selevy_ctrl
  import selevy_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  selevy_ctrl_if.master    bus,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  state_t           state_r;
  state_t           state_next_s;
  logic [6:0]       op_r;
  logic             illegal_r;
  logic             bus_err_r;
  logic [CNT_W-1:0] instret_r;

  logic       imem_req_s;
  logic       ir_we_s;
  logic       alu_src_imm_s;
  logic       dmem_req_s;
  logic       dmem_we_s;
  logic       pc_we_s;
  logic [1:0] pc_sel_s;
  logic       rf_we_s;
  logic [1:0] wb_sel_s;
  logic       retire_s;
  logic       set_illegal_s;
  logic       set_bus_err_s;

  logic wd_req_s;
  logic wd_ack_s;
  logic wd_clr_s;
  logic wd_expire_s;

  // Only a request actually on the bus can be acknowledged.
  assign wd_req_s = ((state_r == ST_FETCH) & run) | (state_r == ST_MEM);
  assign wd_ack_s = ((state_r == ST_FETCH) & run & bus.imem_ack) |
                    ((state_r == ST_MEM) & bus.dmem_ack);
  assign wd_clr_s = (state_next_s != state_r);

  selevy_ctrl_timeout #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk    (CLK),
    .reset  (reset),
    .req    (wd_req_s),
    .ack    (wd_ack_s),
    .clr    (wd_clr_s),
    .expire (wd_expire_s)
  );

  // Next-state and strobe decode from state, latched opcode and handshakes.
  always_comb begin
    state_next_s  = state_r;
    imem_req_s    = 1'b0;
    ir_we_s       = 1'b0;
    alu_src_imm_s = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    pc_we_s       = 1'b0;
    pc_sel_s      = PC_SEL_SEQ;
    rf_we_s       = 1'b0;
    wb_sel_s      = WB_SEL_ALU;
    retire_s      = 1'b0;
    set_illegal_s = 1'b0;
    set_bus_err_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = run & ~wd_expire_s;
        if (wd_ack_s) begin
          ir_we_s      = 1'b1;
          state_next_s = ST_DECODE;
        end else if (wd_expire_s) begin
          set_bus_err_s = 1'b1;
          state_next_s  = ST_TRAP;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (bus.opcode == OPC_SYSTEM) begin
          state_next_s = ST_HALT;
        end else if (opc_known(bus.opcode)) begin
          state_next_s = ST_EXEC;
        end else begin
          set_illegal_s = 1'b1;
          state_next_s  = ST_TRAP;
        end
      end
      ST_EXEC: begin
        alu_src_imm_s = opc_uses_imm(op_r);
        if ((op_r == OPC_LOAD) || (op_r == OPC_STORE)) begin
          state_next_s = ST_MEM;
        end else if (op_r == OPC_BRANCH) begin
          pc_we_s      = 1'b1;
          pc_sel_s     = bus.branch_taken ? PC_SEL_REL : PC_SEL_SEQ;
          retire_s     = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_s = ~wd_expire_s;
        dmem_we_s  = (op_r == OPC_STORE) & ~wd_expire_s;
        if (wd_ack_s) begin
          if (op_r == OPC_STORE) begin
            pc_we_s      = 1'b1;
            retire_s     = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_WB;
          end
        end else if (wd_expire_s) begin
          set_bus_err_s = 1'b1;
          state_next_s  = ST_TRAP;
        end else begin
          state_next_s = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_s      = 1'b1;
        pc_we_s      = 1'b1;
        wb_sel_s     = wb_sel_for(op_r);
        pc_sel_s     = pc_sel_for(op_r);
        retire_s     = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_HALT, ST_TRAP: begin
        state_next_s = state_r;
      end
      default: begin
        state_next_s = ST_TRAP;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latched opcode, sticky trap causes and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      op_r      <= 7'd0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
      instret_r <= '0;
    end else begin
      op_r      <= (state_r == ST_DECODE) ? bus.opcode : op_r;
      illegal_r <= illegal_r | set_illegal_s;
      bus_err_r <= bus_err_r | set_bus_err_s;
      instret_r <= retire_s ? (instret_r + CNT_W'(1)) : instret_r;
    end
  end

  // Strobes are suppressed during the reset cycle itself.
  assign bus.imem_req    = imem_req_s & ~reset;
  assign bus.ir_we       = ir_we_s & ~reset;
  assign bus.dmem_req    = dmem_req_s & ~reset;
  assign bus.dmem_we     = dmem_we_s & ~reset;
  assign bus.pc_we       = pc_we_s & ~reset;
  assign bus.rf_we       = rf_we_s & ~reset;
  assign bus.alu_src_imm = alu_src_imm_s;
  assign bus.pc_sel      = pc_sel_s;
  assign bus.wb_sel      = wb_sel_s;

  assign state   = state_r;
  assign halted  = (state_r == ST_HALT) || (state_r == ST_TRAP);
  assign illegal = illegal_r;
  assign bus_err = bus_err_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_selevy_ctrl.sv
// Directed bench for selevy_ctrl: an instruction-level model expands each
// instruction into expected per-cycle rows, checked every cycle.
module tb_selevy_ctrl;

  localparam int TO = 16;

  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_SYSTEM = 7'b1110011;
  localparam logic [6:0] O_BAD    = 7'b1111111;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       ir_we;
    logic       alu_imm;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       halted;
    logic       illegal;
    logic       bus_err;
    logic [3:0] instret;
  } row_t;

  logic       clk;
  logic       reset;
  logic       run;
  logic [2:0] state;
  logic       halted;
  logic       illegal;
  logic       bus_err;
  logic [3:0] instret;

  selevy_ctrl_if bus ();

  selevy_ctrl #(
    .CNT_W       (4),
    .MEM_TIMEOUT (TO)
  ) dut (
    .CLK     (clk),
    .reset   (reset),
    .run     (run),
    .bus     (bus),
    .state   (state),
    .halted  (halted),
    .illegal (illegal),
    .bus_err (bus_err),
    .instret (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  row_t exp_q[$];
  row_t obs;

  // Model state: only what the programmer-visible outputs depend on.
  logic [2:0] m_state;
  logic       m_ill;
  logic       m_berr;
  logic [3:0] m_instret;

  assign obs = {state, bus.imem_req, bus.ir_we, bus.alu_src_imm, bus.dmem_req,
                bus.dmem_we, bus.pc_we, bus.pc_sel, bus.rf_we, bus.wb_sel,
                halted, illegal, bus_err, instret};

  always @(negedge clk) begin
    row_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL row t=%0t state=%0d: got %h want %h", $time, e.state, obs, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic known(input logic [6:0] o);
    return (o == O_LOAD) || (o == O_STORE) || (o == O_OP) || (o == O_OPIMM) ||
           (o == O_BRANCH) || (o == O_JAL) || (o == O_JALR) || (o == O_LUI) ||
           (o == O_AUIPC);
  endfunction

  function automatic logic imm_op(input logic [6:0] o);
    return (o == O_OPIMM) || (o == O_LOAD) || (o == O_STORE) || (o == O_LUI) ||
           (o == O_AUIPC) || (o == O_JALR);
  endfunction

  function automatic row_t base(input logic [2:0] st);
    row_t r;
    r         = '0;
    r.state   = st;
    r.halted  = (st == 3'd5) || (st == 3'd6);
    r.illegal = m_ill;
    r.bus_err = m_berr;
    r.instret = m_instret;
    return r;
  endfunction

  task automatic step(input logic rs, input logic r, input logic ia, input logic da,
                      input logic bt, input logic [6:0] opc, input row_t e);
    reset            = rs;
    run              = r;
    bus.imem_ack     = ia;
    bus.dmem_ack     = da;
    bus.branch_taken = bt;
    bus.opcode       = opc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic do_reset(input logic [2:0] st);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_OP, base(st));
    m_state   = 3'd0;
    m_ill     = 1'b0;
    m_berr    = 1'b0;
    m_instret = 4'd0;
  endtask

  // Expand one instruction into its expected cycle rows. The opcode bus only
  // carries the real opcode in DECODE so later phases must use the latched copy.
  task automatic do_instr(input logic [6:0] opc, input logic taken, input int idly,
                          input int ddly, input logic rmid);
    row_t e;
    for (int k = 0; k <= idly; k++) begin
      e = base(3'd0);
      if (k == idly) begin
        e.imem_req = 1'b1;
        e.ir_we    = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, taken, O_BAD, e);
      end else if (k == TO - 2) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, taken, O_BAD, e);
        m_berr  = 1'b1;
        m_state = 3'd6;
        return;
      end else begin
        e.imem_req = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b1, taken, O_BAD, e);
      end
    end
    step(1'b0, rmid, 1'b0, 1'b0, taken, opc, base(3'd1));
    if (opc == O_SYSTEM) begin
      m_state = 3'd5;
      return;
    end
    if (!known(opc)) begin
      m_ill   = 1'b1;
      m_state = 3'd6;
      return;
    end
    e = base(3'd2);
    e.alu_imm = imm_op(opc);
    if (opc == O_BRANCH) begin
      e.pc_we  = 1'b1;
      e.pc_sel = taken ? 2'b01 : 2'b00;
      step(1'b0, rmid, 1'b0, 1'b0, taken, O_BAD, e);
      m_instret = m_instret + 4'd1;
      return;
    end
    step(1'b0, rmid, 1'b0, 1'b0, taken, O_BAD, e);
    if ((opc == O_LOAD) || (opc == O_STORE)) begin
      for (int k = 0; k <= ddly; k++) begin
        e = base(3'd3);
        e.dmem_req = 1'b1;
        e.dmem_we  = (opc == O_STORE);
        e.pc_we    = (opc == O_STORE) && (k == ddly);
        step(1'b0, rmid, 1'b1, (k == ddly), taken, O_BAD, e);
      end
      if (opc == O_STORE) begin
        m_instret = m_instret + 4'd1;
        return;
      end
    end
    e = base(3'd4);
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = (opc == O_LOAD) ? 2'b01 : ((opc == O_JAL) || (opc == O_JALR)) ? 2'b10 : 2'b00;
    e.pc_sel = (opc == O_JAL) ? 2'b01 : (opc == O_JALR) ? 2'b10 : 2'b00;
    step(1'b0, rmid, 1'b0, 1'b0, taken, O_BAD, e);
    m_instret = m_instret + 4'd1;
  endtask

  // Cycles in a parked state with run toggling and stray acks.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, i[0], 1'b1, 1'b1, 1'b0, O_OP, base(m_state));
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_OP, base(3'd0));
    end
  endtask

  initial begin
    row_t e;
    reset            = 1'b1;
    run              = 1'b0;
    bus.imem_ack     = 1'b0;
    bus.dmem_ack     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.opcode       = 7'd0;
    m_state = 3'd0; m_ill = 1'b0; m_berr = 1'b0; m_instret = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(3'd0);
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_instret", {28'd0, instret}, 32'd0);

    do_instr(O_OP, 1'b0, 0, 0, 1'b1);
    chk("op_instret", {28'd0, instret}, 32'd1);
    do_instr(O_LOAD, 1'b0, 1, 3, 1'b1);
    do_instr(O_BRANCH, 1'b1, 0, 0, 1'b1);
    do_instr(O_BRANCH, 1'b0, 2, 0, 1'b1);
    chk("branch_instret", {28'd0, instret}, 32'd4);
    do_instr(O_STORE, 1'b1, 0, 1, 1'b1);
    do_instr(O_JAL, 1'b1, 0, 0, 1'b1);
    do_instr(O_JALR, 1'b1, 0, 0, 1'b1);
    do_instr(O_LUI, 1'b1, 0, 0, 1'b1);
    do_instr(O_AUIPC, 1'b1, 0, 0, 1'b1);
    // run drops mid-instruction: it completes, then fetch stalls.
    do_instr(O_OPIMM, 1'b0, 0, 0, 1'b0);
    stall(3);
    // ack in the expiry cycle wins over the timeout.
    do_instr(O_OP, 1'b0, TO - 2, 0, 1'b1);
    chk("tie_no_trap", {31'd0, bus_err}, 32'd0);
    chk("instret_11", {28'd0, instret}, 32'd11);
    for (int i = 0; i < 5; i++) begin
      do_instr(O_OP, 1'b0, 0, 0, 1'b1);
    end
    chk("instret_wrap", {28'd0, instret}, 32'd0);

    do_instr(O_SYSTEM, 1'b0, 0, 0, 1'b1);
    idle(4);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_instret", {28'd0, instret}, 32'd0);
    do_reset(3'd5);
    chk("halt_reset_state", {29'd0, state}, 32'd0);

    do_instr(O_BAD, 1'b0, 0, 0, 1'b1);
    idle(3);
    chk("trap_illegal", {31'd0, illegal}, 32'd1);
    chk("trap_state", {29'd0, state}, 32'd6);
    do_reset(3'd6);
    chk("trap_reset_illegal", {31'd0, illegal}, 32'd0);

    do_instr(O_OP, 1'b0, 20, 0, 1'b1);
    idle(3);
    chk("timeout_bus_err", {31'd0, bus_err}, 32'd1);
    do_reset(3'd6);

    // Reset while a store waits in MEM, with dmem_ack arriving in that cycle.
    e = base(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_BAD, e);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_STORE, base(3'd1));
    e = base(3'd2); e.alu_imm = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_BAD, e);
    e = base(3'd3); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_BAD, e);
    do_reset(3'd3);
    e = base(3'd0); e.imem_req = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_BAD, e);
    chk("mem_reset_instret", {28'd0, instret}, 32'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
